mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the instruction-fetch port (PC/IM side) and the data port (DM side, LW/SW).
- Replaces the separate IM/DM instances in the datapath.
- Sequences each access through a small FSM and returns a one-cycle ready pulse with the data.
- Arbitrates with data priority plus a fairness guard, so fetch is never starved.

Parameters:
- ADDR_W, 16, address width of both ports and of the memory.
- DATA_W, 16, data width.
- LAT, 2, memory read latency in cycles from the mem_en cycle to mem_rdata valid. Legal range 1..7.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- hlt  in  1  halt request from the decoder; blocks new grants.
- i_req  in  1  fetch request; held until i_rdy.
- i_addr  in  ADDR_W  fetch address; stable while i_req is high.
- i_rdy  out  1  one-cycle fetch completion pulse.
- i_data  out  DATA_W  fetched instruction; valid with i_rdy, held until the next fetch response.
- d_re  in  1  data read request.
- d_we  in  1  data write request.
- d_addr  in  ADDR_W  data address (ALU result).
- d_wdata  in  DATA_W  store data.
- d_rdy  out  1  one-cycle data completion pulse.
- d_rdata  out  DATA_W  load data; valid with d_rdy, held until the next data read response.
- mem_en  out  1  memory access strobe; exactly one cycle per access.
- mem_we  out  1  write qualifier for mem_en.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid LAT cycles after mem_en.
- busy  out  1  high whenever the FSM is not IDLE.
- err  out  1  sticky flag: d_re and d_we were seen together at a grant.

Behaviour:
- Reset:
  - rst=1 at an edge puts the FSM in IDLE.
  - All outputs go to 0 (i_data, d_rdata, mem_addr, mem_wdata included); err clears; last_grant=FETCH.
  - Reset mid-access abandons the access: no rdy pulse, and mem_en is not re-issued.
- States: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- IDLE:
  - Arbitrates on any edge where hlt=0 and at least one request is pending.
  - The winner's address, write data and kind are latched; next state is ISSUE.
  - With hlt=1 the FSM stays in IDLE; requests stay pending with no side effects.
- Arbitration:
  - Data wins if pending, unless last_grant==DATA and i_req=1; in that case fetch wins.
  - Result: after a data grant, a waiting fetch is served next.
  - last_grant updates at every grant.
  - d_re and d_we both high: treated as a write, err is set.
- ISSUE (1 cycle): mem_en=1; mem_we=1 for writes.
  - Write: next state RESP.
  - Read: next state WAIT with counter = LAT-1.
- WAIT: counter decrements each cycle. At counter==0, mem_rdata is captured into i_data or d_rdata (per the latched owner); next state RESP.
  - LAT=1 leaves WAIT after exactly one cycle.
- RESP (1 cycle): the owner's rdy=1; next state IDLE. Requests are not sampled in RESP, so a requester that drops req on rdy is never double-served.
- Latency, measured from the IDLE edge that grants:
  - Write: d_rdy 2 cycles later.
  - Read: rdy LAT+2 cycles later.
  - Minimum back-to-back period: write 3 cycles, read LAT+3 cycles.
- hlt rising during ISSUE/WAIT/RESP: the in-flight access completes normally; no grant is made afterwards.
- Requests that drop before their grant are simply not served. No queueing beyond the live request lines.

Decomposition:
- Shared package mem_arb_pkg:
  - state enum {IDLE, ISSUE, WAIT, RESP};
  - owner enum {FETCH, DATA};
  - constant LAT_W = 3 (counter width).
- Sub-module: arb_pick, a combinational priority/fairness picker. Inputs i_req, d_pending, last_grant; outputs grant_valid and grant_owner. The FSM, counter and response registers stay in the top.

Test Plan:
- Reset then single fetch: i_req=1, i_addr=0x0010, mem returns 0xB123 (LAT=2) -> mem_en one cycle with mem_addr=0x0010, i_rdy 4 cycles after grant, i_data=0xB123, busy low afterwards.
- Simultaneous i_req and d_re at 0x0040, last_grant=FETCH -> data served first; fetch granted in the next IDLE. Repeat with d_re held -> grants alternate D, F, D, F.
- Store: d_we=1, d_addr=0x0100, d_wdata=0xBEEF -> one mem_en with mem_we=1 and those values, d_rdy 2 cycles after grant; a following read of 0x0100 returns 0xBEEF.
- hlt=1 asserted during WAIT of a fetch -> that i_rdy still fires; pending d_re is never granted; mem_en stays 0 while hlt is held.
- rst pulsed in WAIT -> no rdy pulse, all outputs 0 on the next cycle, no extra mem_en.
- d_re=d_we=1 at grant -> write performed, err=1 and stays set until rst. Sweep LAT=1 and LAT=7 -> read rdy at 3 and 9 cycles after grant.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states, port owners
// and the width of the read-latency counter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    typedef enum logic {
        FETCH = 1'b0,
        DATA  = 1'b1
    } owner_e;

    localparam int LAT_W = 3;

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Combinational picker: data has priority, but a fetch waiting behind a data
// grant always wins the next arbitration so the fetch side is never starved.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic   i_req,
    input  logic   d_pending,
    input  owner_e last_grant,
    output logic   grant_valid,
    output owner_e grant_owner
);

    always_comb begin
        grant_valid = i_req | d_pending;
        grant_owner = FETCH;
        if (d_pending && !(last_grant == DATA && i_req)) begin
            grant_owner = DATA;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-ported unified memory shared between instruction fetch and data
// load/store; each access is sequenced IDLE -> ISSUE -> (WAIT) -> RESP.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int LAT    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hlt,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_rdy,
    output logic [DATA_W-1:0] i_data,
    input  logic              d_re,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_rdy,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              err
);

    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LAT - 1);

    state_e             state_q;
    owner_e             owner_q;
    owner_e             last_grant_q;
    logic [LAT_W-1:0]   cnt_q;
    logic               i_rdy_q;
    logic               d_rdy_q;
    logic [DATA_W-1:0]  i_data_q;
    logic [DATA_W-1:0]  d_rdata_q;
    logic               mem_en_q;
    logic               mem_we_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic [DATA_W-1:0]  mem_wdata_q;
    logic               busy_q;
    logic               err_q;

    logic               grant_valid;
    owner_e             grant_owner;

    arb_pick u_pick (
        .i_req       (i_req),
        .d_pending   (d_re | d_we),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    // mem_we_q doubles as the latched access kind while the access is in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= FETCH;
            last_grant_q <= FETCH;
            cnt_q        <= '0;
            i_rdy_q      <= 1'b0;
            d_rdy_q      <= 1'b0;
            i_data_q     <= '0;
            d_rdata_q    <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            mem_en_q <= 1'b0;
            i_rdy_q  <= 1'b0;
            d_rdy_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!hlt && grant_valid) begin
                        state_q      <= ISSUE;
                        busy_q       <= 1'b1;
                        owner_q      <= grant_owner;
                        last_grant_q <= grant_owner;
                        mem_en_q     <= 1'b1;
                        if (grant_owner == DATA) begin
                            mem_addr_q  <= d_addr;
                            mem_we_q    <= d_we;
                            mem_wdata_q <= d_we ? d_wdata : '0;
                            if (d_re && d_we) begin
                                err_q <= 1'b1;
                            end
                        end else begin
                            mem_addr_q  <= i_addr;
                            mem_we_q    <= 1'b0;
                            mem_wdata_q <= '0;
                        end
                    end
                end
                ISSUE: begin
                    mem_we_q <= 1'b0;
                    if (mem_we_q) begin
                        state_q <= RESP;
                        d_rdy_q <= 1'b1;
                    end else begin
                        state_q <= WAIT;
                        cnt_q   <= LAT_LAST;
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= RESP;
                        if (owner_q == DATA) begin
                            d_rdata_q <= mem_rdata;
                            d_rdy_q   <= 1'b1;
                        end else begin
                            i_data_q <= mem_rdata;
                            i_rdy_q  <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - LAT_W'(1);
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign i_rdy     = i_rdy_q;
    assign i_data    = i_data_q;
    assign d_rdy     = d_rdy_q;
    assign d_rdata   = d_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (LAT = 2, 1, 7) share stimulus,
// each backed by its own behavioural memory with the matching read latency.
module tb_mem_port_arbiter;

    localparam int NDUT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        hlt;
    logic        i_req;
    logic [15:0] i_addr;
    logic        d_re;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;

    logic        i_rdy_a     [NDUT];
    logic        d_rdy_a     [NDUT];
    logic        mem_en_a    [NDUT];
    logic        mem_we_a    [NDUT];
    logic        busy_a      [NDUT];
    logic        err_a       [NDUT];
    logic [15:0] i_data_a    [NDUT];
    logic [15:0] d_rdata_a   [NDUT];
    logic [15:0] mem_addr_a  [NDUT];
    logic [15:0] mem_wdata_a [NDUT];

    int passCount  = 0;
    int checkCount = 0;
    int memEnCount = 0;

    always #5 clk = ~clk;

    // Memory model: read data appears for exactly one cycle, LAT cycles after mem_en.
    genvar g;
    generate
        for (g = 0; g < NDUT; g++) begin : gDut
            localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 7);
            logic [15:0] mem [1024];
            logic [15:0] pd [L];
            logic        pv [L];
            logic        memInit = 1'b0;
            logic [15:0] memRdata;

            always @(posedge clk) begin
                if (!memInit) begin
                    for (int a = 0; a < 1024; a++) mem[a] <= 16'hA000 | 16'(a);
                    mem[16] <= 16'hB123;
                    for (int k = 0; k < L; k++) pv[k] <= 1'b0;
                    memInit <= 1'b1;
                end else begin
                    if (mem_en_a[g] && mem_we_a[g]) mem[mem_addr_a[g][9:0]] <= mem_wdata_a[g];
                    pv[0] <= mem_en_a[g] && !mem_we_a[g];
                    pd[0] <= mem[mem_addr_a[g][9:0]];
                    for (int k = 1; k < L; k++) begin
                        pv[k] <= pv[k-1];
                        pd[k] <= pd[k-1];
                    end
                end
            end

            assign memRdata = (pv[L-1] === 1'b1) ? pd[L-1] : 16'h0BAD;

            mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .LAT(L)) dut (
                .clk       (clk),
                .rst       (rst),
                .hlt       (hlt),
                .i_req     (i_req),
                .i_addr    (i_addr),
                .i_rdy     (i_rdy_a[g]),
                .i_data    (i_data_a[g]),
                .d_re      (d_re),
                .d_we      (d_we),
                .d_addr    (d_addr),
                .d_wdata   (d_wdata),
                .d_rdy     (d_rdy_a[g]),
                .d_rdata   (d_rdata_a[g]),
                .mem_en    (mem_en_a[g]),
                .mem_we    (mem_we_a[g]),
                .mem_addr  (mem_addr_a[g]),
                .mem_wdata (mem_wdata_a[g]),
                .mem_rdata (memRdata),
                .busy      (busy_a[g]),
                .err       (err_a[g])
            );
        end
    endgenerate

    always @(posedge clk) begin
        if (mem_en_a[0] === 1'b1) memEnCount++;
    end

    typedef struct {
        logic        isFetch;
        logic        isWrite;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] expData;
        int          expLat;
    } vec_t;

    vec_t vecs [5];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic dropRequests();
        i_req   = 1'b0;
        d_re    = 1'b0;
        d_we    = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        hlt = 1'b0;
        dropRequests();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Returns at the negedge of the ISSUE cycle (cycle 1 after the granting IDLE cycle).
    task automatic waitGrant(output logic seen);
        seen = 1'b0;
        for (int n = 0; n < 30 && !seen; n++) begin
            @(negedge clk);
            if (mem_en_a[0] === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic waitRdy(input logic isFetch, input int startCycle, output int cycles);
        logic done;
        done   = 1'b0;
        cycles = startCycle;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            cycles++;
            if ((isFetch ? i_rdy_a[0] : d_rdy_a[0]) === 1'b1) done = 1'b1;
        end
        if (!done) cycles = -1;
    endtask

    task automatic applyStimulus(input int idx, input vec_t v);
        logic seen;
        int   cyc;
        int   enStart;
        enStart = memEnCount;
        if (v.isFetch) begin
            i_req  = 1'b1;
            i_addr = v.addr;
        end else begin
            d_re    = !v.isWrite;
            d_we    = v.isWrite;
            d_addr  = v.addr;
            d_wdata = v.wdata;
        end
        waitGrant(seen);
        checkOutput($sformatf("vec%0d_grant", idx), 32'(seen), 32'd1);
        checkOutput($sformatf("vec%0d_mem_addr", idx), 32'(mem_addr_a[0]), 32'(v.addr));
        checkOutput($sformatf("vec%0d_mem_we", idx), 32'(mem_we_a[0]), 32'(v.isWrite));
        if (v.isWrite) checkOutput($sformatf("vec%0d_mem_wdata", idx), 32'(mem_wdata_a[0]), 32'(v.wdata));
        waitRdy(v.isFetch, 1, cyc);
        checkOutput($sformatf("vec%0d_latency", idx), 32'(cyc), 32'(v.expLat));
        if (!v.isWrite) begin
            checkOutput($sformatf("vec%0d_rdata", idx),
                        32'(v.isFetch ? i_data_a[0] : d_rdata_a[0]), 32'(v.expData));
        end
        dropRequests();
        @(negedge clk);
        checkOutput($sformatf("vec%0d_busy_after", idx), 32'(busy_a[0]), 32'd0);
        checkOutput($sformatf("vec%0d_mem_en_count", idx), 32'(memEnCount - enStart), 32'd1);
    endtask

    initial begin
        logic seen;
        int   cyc;
        int   enStart;
        logic rdySeen;
        int   rdyCyc [NDUT];
        int   expLat [NDUT];
        vec_t v;

        vecs[0] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'hB123, 4};
        vecs[1] = '{1'b0, 1'b0, 16'h0040, 16'h0000, 16'hA040, 4};
        vecs[2] = '{1'b0, 1'b1, 16'h0100, 16'hBEEF, 16'h0000, 2};
        vecs[3] = '{1'b0, 1'b0, 16'h0100, 16'h0000, 16'hBEEF, 4};
        vecs[4] = '{1'b1, 1'b0, 16'h0100, 16'h0000, 16'hBEEF, 4};
        expLat  = '{4, 3, 9};

        i_addr  = 16'h0;
        d_addr  = 16'h0;
        d_wdata = 16'h0;
        doReset();

        checkOutput("reset_busy", 32'(busy_a[0]), 32'd0);
        checkOutput("reset_err", 32'(err_a[0]), 32'd0);
        checkOutput("reset_mem_en", 32'(mem_en_a[0]), 32'd0);
        checkOutput("reset_rdy", 32'({i_rdy_a[0], d_rdy_a[0]}), 32'd0);
        checkOutput("reset_data", 32'({i_data_a[0], d_rdata_a[0]}), 32'd0);
        checkOutput("reset_mem_bus", 32'({mem_addr_a[0], mem_wdata_a[0]}), 32'd0);

        for (int i = 0; i < 5; i++) applyStimulus(i, vecs[i]);

        // Arbitration: data first after reset, then strict alternation while both are held.
        doReset();
        i_req  = 1'b1;
        i_addr = 16'h0010;
        d_re   = 1'b1;
        d_addr = 16'h0040;
        for (int n = 0; n < 4; n++) begin
            waitGrant(seen);
            checkOutput($sformatf("arb_grant%0d_seen", n), 32'(seen), 32'd1);
            checkOutput($sformatf("arb_grant%0d_addr", n), 32'(mem_addr_a[0]),
                        (n % 2 == 0) ? 32'h0040 : 32'h0010);
        end
        waitRdy(1'b1, 1, cyc);
        checkOutput("arb_fetch_latency", 32'(cyc), 32'd4);
        checkOutput("arb_i_data", 32'(i_data_a[0]), 32'hB123);
        checkOutput("arb_d_rdata", 32'(d_rdata_a[0]), 32'hA040);
        dropRequests();
        @(negedge clk);

        // Halt raised during WAIT of a fetch: fetch completes, pending data read waits.
        doReset();
        i_req  = 1'b1;
        i_addr = 16'h0010;
        waitGrant(seen);
        checkOutput("hlt_fetch_grant", 32'(seen), 32'd1);
        d_re   = 1'b1;
        d_addr = 16'h0040;
        @(negedge clk);
        hlt = 1'b1;
        waitRdy(1'b1, 2, cyc);
        checkOutput("hlt_fetch_latency", 32'(cyc), 32'd4);
        checkOutput("hlt_i_data", 32'(i_data_a[0]), 32'hB123);
        i_req = 1'b0;
        enStart = memEnCount;
        rdySeen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (d_rdy_a[0] === 1'b1) rdySeen = 1'b1;
        end
        checkOutput("hlt_no_mem_en", 32'(memEnCount - enStart), 32'd0);
        checkOutput("hlt_no_d_rdy", 32'(rdySeen), 32'd0);
        checkOutput("hlt_busy", 32'(busy_a[0]), 32'd0);
        hlt = 1'b0;
        waitGrant(seen);
        checkOutput("hlt_release_grant", 32'(seen), 32'd1);
        checkOutput("hlt_release_addr", 32'(mem_addr_a[0]), 32'h0040);
        waitRdy(1'b0, 1, cyc);
        checkOutput("hlt_release_d_rdata", 32'(d_rdata_a[0]), 32'hA040);
        dropRequests();
        @(negedge clk);

        // Reset during WAIT: outputs (including previously loaded data) clear, no rdy, no re-issue.
        i_req  = 1'b1;
        i_addr = 16'h0010;
        waitGrant(seen);
        checkOutput("rstwait_grant", 32'(seen), 32'd1);
        @(negedge clk);
        rst   = 1'b1;
        i_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        enStart = memEnCount;
        checkOutput("rstwait_busy", 32'(busy_a[0]), 32'd0);
        checkOutput("rstwait_rdy", 32'({i_rdy_a[0], d_rdy_a[0]}), 32'd0);
        checkOutput("rstwait_data", 32'({i_data_a[0], d_rdata_a[0]}), 32'd0);
        checkOutput("rstwait_mem_en", 32'(mem_en_a[0]), 32'd0);
        checkOutput("rstwait_mem_addr", 32'(mem_addr_a[0]), 32'd0);
        rdySeen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (i_rdy_a[0] === 1'b1 || d_rdy_a[0] === 1'b1) rdySeen = 1'b1;
        end
        checkOutput("rstwait_no_rdy", 32'(rdySeen), 32'd0);
        checkOutput("rstwait_no_mem_en", 32'(memEnCount - enStart), 32'd0);

        // Read and write requested together: performed as a write, err sticks until reset.
        d_re    = 1'b1;
        d_we    = 1'b1;
        d_addr  = 16'h0200;
        d_wdata = 16'h1234;
        waitGrant(seen);
        checkOutput("err_grant", 32'(seen), 32'd1);
        checkOutput("err_mem_we", 32'(mem_we_a[0]), 32'd1);
        checkOutput("err_mem_wdata", 32'(mem_wdata_a[0]), 32'h1234);
        checkOutput("err_set", 32'(err_a[0]), 32'd1);
        waitRdy(1'b0, 1, cyc);
        checkOutput("err_write_latency", 32'(cyc), 32'd2);
        dropRequests();
        repeat (3) @(negedge clk);
        checkOutput("err_sticky", 32'(err_a[0]), 32'd1);
        v = '{1'b0, 1'b0, 16'h0200, 16'h0000, 16'h1234, 4};
        applyStimulus(5, v);
        checkOutput("err_sticky_after_read", 32'(err_a[0]), 32'd1);
        doReset();
        checkOutput("err_cleared", 32'(err_a[0]), 32'd0);

        // Latency sweep: one data read granted simultaneously in all three instances.
        d_re   = 1'b1;
        d_addr = 16'h0040;
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            checkOutput($sformatf("sweep%0d_mem_en", k), 32'(mem_en_a[k]), 32'd1);
            rdyCyc[k] = 0;
        end
        d_re = 1'b0;
        for (int c = 2; c < 15; c++) begin
            @(negedge clk);
            for (int k = 0; k < NDUT; k++) begin
                if (d_rdy_a[k] === 1'b1 && rdyCyc[k] == 0) begin
                    rdyCyc[k] = c;
                    checkOutput($sformatf("sweep%0d_d_rdata", k), 32'(d_rdata_a[k]), 32'hA040);
                end
            end
        end
        for (int k = 0; k < NDUT; k++) begin
            checkOutput($sformatf("sweep%0d_latency", k), 32'(rdyCyc[k]), 32'(expLat[k]));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached, %0d/%0d so far", passCount, checkCount);
        $fatal(1, "[TB] watchdog");
    end

endmodule
